// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared definitions for the instruction/data memory arbiter.
//            It holds the FSM state encoding and the default values of the
//            word width, watchdog limit and watchdog counter width.
// Ports    : none (package)
// Options  : MEM_ARB_ROUND_ROBIN_EN (used by mem_arbiter, not here)
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MEM_I = 2'd1,
    MEM_D = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_TIMEOUT   = 255;
  localparam int DEF_TW        = 8;

endpackage
`default_nettype wire

// File: rtl/mem_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : mem_watchdog
// Purpose  : Response watchdog for the memory arbiter. It counts the cycles
//            spent waiting for memory and flags when the limit is reached.
// Ports    : clk     - clock, rising edge
//            reset_n - asynchronous active-low reset
//            clear   - zero the counter (takes precedence over enable)
//            enable  - count this cycle (arbiter is waiting on memory)
//            expire  - high while enabled and the count equals TIMEOUT
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module mem_watchdog
  import mem_arbiter_pkg::*;
#(
  parameter int TW      = DEF_TW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // The arbiter leaves the wait state on expiry, so the counter never has
  // to run past LIMIT.
  assign expire = enable && (count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one single-port memory between the instruction-fetch (I)
//            and load/store (D) ports of the CPU, using a readM/writeM strobe
//            handshake, with a watchdog that aborts stalled accesses.
// Ports    : clk, reset_n                    - clock / async active-low reset
//            i_req, i_addr                   - fetch request and address
//            i_rdata, i_done                 - fetched word, completion pulse
//            d_req, d_we, d_addr, d_wdata    - data request (we=1 store)
//            d_rdata, d_done                 - load data, completion pulse
//            readM, writeM, m_address,
//            m_wdata                         - memory strobes / address / data
//            m_rdata, inputReady, ackOutput  - memory read data / responses
//            err                             - pulse on watchdog abort
//            busy                            - high whenever not IDLE
// Options  : MEM_ARB_ROUND_ROBIN_EN - on contention grant the port that was
//            not granted last instead of fixed D-over-I priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int TW        = DEF_TW
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] m_address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 err,
  output logic                 busy
);

  arb_state_t state, state_nx;

  logic                 grant_i, grant_d;
  logic                 resp_ok, abort, wd_en, expire;
  logic [WORD_SIZE-1:0] addr_q, wdata_q;
  logic                 we_q;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // 1 = D was granted most recently; reset makes I win the first tie.
  logic last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_d <= 1'b1;
    end else if (grant_d || grant_i) begin
      last_d <= grant_d;
    end
  end
`endif

  mem_watchdog #(
    .TW      (TW),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (grant_i || grant_d),
    .enable  (wd_en),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    resp_ok  = 1'b0;
    abort    = 1'b0;
    wd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && i_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
          grant_i = last_d;
          grant_d = !last_d;
`else
          grant_d = 1'b1;
`endif
        end else if (d_req) begin
          grant_d = 1'b1;
        end else if (i_req) begin
          grant_i = 1'b1;
        end
        if (grant_d) begin
          state_nx = MEM_D;
        end else if (grant_i) begin
          state_nx = MEM_I;
        end
      end
      MEM_I, MEM_D: begin
        wd_en = 1'b1;
        // A response only counts when it matches the strobe currently
        // driven; this also ignores responses before the strobe is up.
        resp_ok = (readM && inputReady) || (writeM && ackOutput);
        abort   = expire && !resp_ok;
        if (resp_ok || abort) begin
          state_nx = RESP;
        end
      end
      RESP: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      readM     <= 1'b0;
      writeM    <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      err       <= 1'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;

      // Snapshot the winner's request so later input changes are ignored.
      if (grant_i || grant_d) begin
        addr_q  <= grant_d ? d_addr : i_addr;
        wdata_q <= d_wdata;
        we_q    <= grant_d && d_we;
      end

      if ((state == MEM_I || state == MEM_D) && !resp_ok && !abort) begin
        readM     <= !we_q;
        writeM    <= we_q;
        m_address <= addr_q;
        m_wdata   <= we_q ? wdata_q : '0;
      end else begin
        readM  <= 1'b0;
        writeM <= 1'b0;
      end

      if (resp_ok) begin
        if (state == MEM_I) begin
          i_done  <= 1'b1;
          i_rdata <= m_rdata;
        end else begin
          d_done <= 1'b1;
          if (!we_q) begin
            d_rdata <= m_rdata;
          end
        end
      end

      if (abort) begin
        err <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a scoreboard
//            of expected accesses (port, address, data) consumed in order.
// Ports    : none
// Options  : MEM_ARB_ROUND_ROBIN_EN - selects the tie-break expectation
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct packed {
    logic         is_d;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_req = 1'b0;
  logic [W-1:0] i_addr = '0;
  logic [W-1:0] i_rdata;
  logic         i_done;
  logic         d_req = 1'b0;
  logic         d_we = 1'b0;
  logic [W-1:0] d_addr = '0;
  logic [W-1:0] d_wdata = '0;
  logic [W-1:0] d_rdata;
  logic         d_done;
  logic         readM, writeM;
  logic [W-1:0] m_address, m_wdata;
  logic [W-1:0] m_rdata = 16'hDEAD;
  logic         inputReady = 1'b0;
  logic         ackOutput = 1'b0;
  logic         err, busy;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] exp_i_rdata = '0;
  logic [W-1:0] exp_d_rdata = '0;
  logic         last_d = 1'b1;

  always #5 clk = ~clk;

  mem_arbiter #(
    .WORD_SIZE (W),
    .TIMEOUT   (TO),
    .TW        (8)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_done     (i_done),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_done     (d_done),
    .readM      (readM),
    .writeM     (writeM),
    .m_address  (m_address),
    .m_wdata    (m_wdata),
    .m_rdata    (m_rdata),
    .inputReady (inputReady),
    .ackOutput  (ackOutput),
    .err        (err),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (readM || writeM) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Serve the next scoreboard entry as the memory: check the strobe, answer
  // after 'delay' cycles, then check the completion pulse and read data.
  task automatic complete(input bit stray_ack, input int delay);
    exp_t e;
    bit   ok;
    e = sb.pop_front();
    wait_strobe(ok);
    check("strobe_seen", 64'(ok), 64'(1));
    check("m_address", 64'(m_address), 64'(e.addr));
    check("strobe_kind", 64'({readM, writeM}), 64'({!e.we, e.we}));
    if (e.we) check("m_wdata", 64'(m_wdata), 64'(e.wdata));
    if (stray_ack) begin
      ackOutput = 1'b1;
      @(negedge clk);
      ackOutput = 1'b0;
      check("stray_ack", 64'({readM, i_done, d_done, busy}), 64'(4'b1001));
    end
    repeat (delay) begin
      @(negedge clk);
      check("strobe_hold", 64'({readM, writeM, m_address}), 64'({!e.we, e.we, e.addr}));
    end
    if (e.we) begin
      ackOutput = 1'b1;
    end else begin
      inputReady = 1'b1;
      m_rdata    = e.rdata;
    end
    @(negedge clk);
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    m_rdata    = 16'hDEAD;
    if (!e.we) begin
      if (e.is_d) exp_d_rdata = e.rdata;
      else        exp_i_rdata = e.rdata;
    end
    check("done_pulse", 64'({i_done, d_done, err}), 64'({!e.is_d, e.is_d, 1'b0}));
    check("strobe_drop", 64'({readM, writeM}), 64'(0));
    check("i_rdata", 64'(i_rdata), 64'(exp_i_rdata));
    check("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
  endtask

  initial begin
    exp_t e;
    bit   ok;
    bit   pick_d;
    int   d_left, i_left, hi, nerr, ndone, nbusy;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_flags", 64'({i_done, d_done, readM, writeM, err, busy}), 64'(0));
    check("reset_data", {i_rdata, d_rdata, m_address, m_wdata}, 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Single fetch, 2-cycle memory delay, with latency check
    i_req  = 1'b1;
    i_addr = 16'h0010;
    e = '{is_d: 1'b0, we: 1'b0, addr: 16'h0010, wdata: '0, rdata: 16'h6A1F};
    sb.push_back(e);
    last_d = 1'b0;
    @(negedge clk);
    check("grant_busy", 64'({busy, readM}), 64'(2'b10));
    complete(1'b0, 2);
    i_req  = 1'b0;
    i_addr = 16'hFFFF;
    @(negedge clk);
    check("i_done_once", 64'(i_done), 64'(0));
    @(negedge clk);
    check("busy_after_fetch", 64'(busy), 64'(0));

    // Store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h00C8;
    d_wdata = 16'hBEEF;
    e = '{is_d: 1'b1, we: 1'b1, addr: 16'h00C8, wdata: 16'hBEEF, rdata: '0};
    sb.push_back(e);
    last_d = 1'b1;
    @(negedge clk);
    d_wdata = 16'h0000;   // changes after the grant must not matter
    complete(1'b0, 1);
    d_req = 1'b0;
    d_we  = 1'b0;
    repeat (2) @(negedge clk);

    // Contention: three loads and three fetches requested together
    d_left = 3;
    i_left = 3;
    d_addr = 16'h0200;
    i_addr = 16'h0100;
    d_req  = 1'b1;
    i_req  = 1'b1;
    for (int n = 0; n < 6; n++) begin
      if (d_left > 0 && i_left > 0) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        pick_d = !last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (d_left > 0);
      end
      e.is_d  = pick_d;
      e.we    = 1'b0;
      e.addr  = pick_d ? d_addr : i_addr;
      e.wdata = '0;
      e.rdata = e.addr ^ 16'hA5A5;
      sb.push_back(e);
      last_d = pick_d;
      complete(1'b0, 0);
      if (pick_d) begin
        d_left--;
        if (d_left == 0) d_req = 1'b0;
        else d_addr = d_addr + 16'h0001;
      end else begin
        i_left--;
        if (i_left == 0) i_req = 1'b0;
        else i_addr = i_addr + 16'h0001;
      end
    end
    repeat (2) @(negedge clk);

    // Watchdog timeout: no response to a fetch
    i_req  = 1'b1;
    i_addr = 16'h0300;
    last_d = 1'b0;
    wait_strobe(ok);
    check("to_strobe_seen", 64'(ok), 64'(1));
    hi    = 0;
    nerr  = 0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (readM) hi++;
      if (i_done) ndone++;
      if (err) begin
        nerr++;
        i_req = 1'b0;
      end
      @(negedge clk);
    end
    check("to_readM_cycles", 64'(hi), 64'(TO));
    check("to_err_pulses", 64'(nerr), 64'(1));
    check("to_no_done", 64'(ndone), 64'(0));
    check("to_rdata_kept", 64'(i_rdata), 64'(exp_i_rdata));
    check("to_idle", 64'(busy), 64'(0));

    // Next request after the abort is serviced normally
    i_req  = 1'b1;
    i_addr = 16'h0304;
    e = '{is_d: 1'b0, we: 1'b0, addr: 16'h0304, wdata: '0, rdata: 16'h4C3B};
    sb.push_back(e);
    complete(1'b0, 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a store
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 16'h0400;
    d_wdata = 16'h1357;
    wait_strobe(ok);
    check("rst_store_strobe", 64'({ok, writeM}), 64'(2'b11));
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_flags", 64'({i_done, d_done, readM, writeM, err, busy}), 64'(0));
    check("rst_async_data", {i_rdata, d_rdata, m_address, m_wdata}, 64'(0));
    d_req       = 1'b0;
    d_we        = 1'b0;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    last_d      = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    nbusy = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (d_done) ndone++;
      if (busy) nbusy++;
    end
    check("rst_no_done", 64'(ndone), 64'(0));
    check("rst_stays_idle", 64'(nbusy), 64'(0));

    // Stray responses while idle
    inputReady = 1'b1;
    ackOutput  = 1'b1;
    m_rdata    = 16'h1234;
    @(negedge clk);
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    m_rdata    = 16'hDEAD;
    check("stray_idle_flags", 64'({busy, i_done, d_done, err}), 64'(0));
    check("stray_idle_rdata", 64'({i_rdata, d_rdata}), 64'(0));

    // ackOutput during a read is ignored, the read then completes normally
    i_req  = 1'b1;
    i_addr = 16'h0500;
    e = '{is_d: 1'b0, we: 1'b0, addr: 16'h0500, wdata: '0, rdata: 16'hA0A5};
    sb.push_back(e);
    last_d = 1'b0;
    complete(1'b1, 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle", 64'(busy), 64'(0));
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "time limit reached");
  end

endmodule
`default_nettype wire
